// File: rtl/warmboot_ctrl.sv
// Sequencer for the iCE40 SB_WARMBOOT primitive: button or timed request,
// S1/S0 setup window, BOOT pulse, then lockout until reset.
module warmboot_ctrl #(
  parameter int DEBOUNCE_LOG2    = 16,
  parameter int AUTO_LOG2        = 22,
  parameter int AUTO_TICKS       = 15,
  parameter int SETUP_CYCLES     = 4,
  parameter int BOOT_HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [1:0] btn_sel,
  input  logic       auto_en,
  input  logic [1:0] auto_image,
  output logic       boot,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       done,
  output logic       heartbeat
);

  localparam int MAXC = (SETUP_CYCLES > BOOT_HOLD_CYCLES) ?
                        SETUP_CYCLES : BOOT_HOLD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [DEBOUNCE_LOG2-1:0] DB_MAX = '1;
  localparam logic [3:0] TICKS = 4'(AUTO_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE, ST_SETUP, ST_FIRE, ST_DONE
  } state_t;

  logic [1:0]               r_sync;
  logic [DEBOUNCE_LOG2-1:0] r_db_cnt;
  logic                     r_stable;
  logic                     r_stable_d;
  logic [AUTO_LOG2-1:0]     r_timer;
  logic                     r_armed;
  logic                     r_hb;
  logic [3:0]               r_tcnt;
  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [1:0]               r_img;
  logic                     r_boot;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_btn_req;
  logic                     w_tick;
  logic                     w_auto_req;
  state_t                   w_state_nx;
  logic [CW-1:0]            w_cnt_nx;
  logic [1:0]               w_img_nx;

  assign w_btn_req  = r_stable & ~r_stable_d;
  assign w_tick     = r_armed && (r_timer == '0);
  assign w_auto_req = (r_tcnt == TICKS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= 2'b00;
      r_db_cnt   <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], btn};
      r_stable_d <= r_stable;
      if (r_sync[1] == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
        r_stable <= r_sync[1];
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // r_armed masks the timer==0 cycle right after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
      r_armed <= 1'b0;
      r_hb    <= 1'b0;
      r_tcnt  <= 4'd0;
    end else begin
      r_timer <= r_timer + 1'b1;
      r_armed <= 1'b1;
      if (w_tick)
        r_hb <= ~r_hb;
      if (!auto_en)
        r_tcnt <= 4'd0;
      else if (w_tick && r_tcnt != TICKS)
        r_tcnt <= r_tcnt + 4'd1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_img_nx   = r_img;
    unique case (r_state)
      ST_IDLE: begin
        if (w_btn_req) begin
          w_img_nx   = btn_sel;
          w_state_nx = ST_SETUP;
          w_cnt_nx   = '0;
        end else if (w_auto_req) begin
          w_img_nx   = auto_image;
          w_state_nx = ST_SETUP;
          w_cnt_nx   = '0;
        end
      end
      ST_SETUP: begin
        if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
          w_state_nx = ST_FIRE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_FIRE: begin
        if (r_cnt == CW'(BOOT_HOLD_CYCLES - 1)) begin
          w_state_nx = ST_DONE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_DONE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // outputs are flops loaded from next state so they are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_img   <= 2'b00;
      r_boot  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_img   <= w_img_nx;
      r_boot  <= (w_state_nx == ST_FIRE);
      r_busy  <= (w_state_nx != ST_IDLE);
      r_done  <= (w_state_nx == ST_DONE);
    end
  end

  assign boot      = r_boot;
  assign s1        = r_img[1];
  assign s0        = r_img[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign heartbeat = r_hb;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Bench for warmboot_ctrl: vector table of request scenarios plus
// hand-written bounce, auto-drop, lockout and mid-pulse reset sequences.
module tb_warmboot_ctrl;

  logic       clk;
  logic       rst;
  logic       btn;
  logic [1:0] btn_sel;
  logic       auto_en;
  logic [1:0] auto_image;
  logic       boot;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       done;
  logic       heartbeat;

  warmboot_ctrl #(
    .DEBOUNCE_LOG2   (3),
    .AUTO_LOG2       (4),
    .AUTO_TICKS      (3),
    .SETUP_CYCLES    (4),
    .BOOT_HOLD_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .btn_sel   (btn_sel),
    .auto_en   (auto_en),
    .auto_image(auto_image),
    .boot      (boot),
    .s1        (s1),
    .s0        (s0),
    .busy      (busy),
    .done      (done),
    .heartbeat (heartbeat)
  );

  typedef struct {
    logic       use_btn;
    logic [1:0] sel;
    logic       aen;
    logic [1:0] aimg;
    int         btn_at;
    int         exp_start;
    logic [1:0] exp_img;
  } vec_t;

  typedef struct {
    logic [1:0] img;
    int         start;
  } exp_t;

  vec_t vecs[6];
  exp_t q[$];
  int   n_run;
  int   n_fail;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("goto_cycle", cyc, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn = 1'b0;
    auto_en = 1'b0;
    btn_sel = 2'b00;
    auto_image = 2'b00;
    @(negedge clk);
    chk("rst_boot", int'(boot), 0);
    chk("rst_s1", int'(s1), 0);
    chk("rst_s0", int'(s0), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hb", int'(heartbeat), 0);
    rst = 1'b0;
  endtask

  task automatic end_checks(input logic [1:0] img);
    chk("end_done", int'(done), 1);
    chk("end_busy", int'(busy), 1);
    chk("end_boot", int'(boot), 0);
    chk("end_img", int'({s1, s0}), int'(img));
    chk("queue_empty", q.size(), 0);
  endtask

  // scoreboard monitor: pops an expected request when busy rises
  logic       pb, pbt, in_seq, bseen;
  logic [1:0] seq_img;
  int         rise, bcnt;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      in_seq = 1'b0;
      pb     = 1'b0;
      pbt    = 1'b0;
    end else begin
      if (busy && !pb) begin
        if (q.size() == 0) begin
          chk("unexpected_seq", 1, 0);
        end else begin
          e = q.pop_front();
          chk("start_cyc", cyc, e.start);
          chk("img_latch", int'({s1, s0}), int'(e.img));
          seq_img = e.img;
        end
        in_seq = 1'b1;
        rise   = cyc;
        bcnt   = 0;
        bseen  = 1'b0;
      end
      if (in_seq) begin
        chk("img_hold", int'({s1, s0}), int'(seq_img));
        if (boot && !pbt) begin
          chk("setup_len", cyc - rise, 4);
          chk("single_pulse", int'(bseen), 0);
        end
        if (boot) bcnt++;
        if (!boot && pbt) begin
          chk("hold_len", bcnt, 8);
          chk("done_after", int'(done), 1);
          bseen = 1'b1;
        end
      end
      pb  = busy;
      pbt = boot;
    end
  end

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    btn = 1'b0;
    btn_sel = 2'b00;
    auto_en = 1'b0;
    auto_image = 2'b00;

    vecs[0] = '{1'b1, 2'b10, 1'b0, 2'b00, 1, 11, 2'b10};
    vecs[1] = '{1'b1, 2'b01, 1'b0, 2'b00, 1, 11, 2'b01};
    vecs[2] = '{1'b0, 2'b00, 1'b1, 2'b01, 0, 50, 2'b01};
    vecs[3] = '{1'b0, 2'b11, 1'b1, 2'b10, 0, 50, 2'b10};
    vecs[4] = '{1'b1, 2'b11, 1'b1, 2'b01, 40, 50, 2'b11};
    vecs[5] = '{1'b1, 2'b00, 1'b1, 2'b11, 5, 15, 2'b00};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      btn_sel = vecs[i].sel;
      auto_en = vecs[i].aen;
      auto_image = vecs[i].aimg;
      q.push_back('{vecs[i].exp_img, vecs[i].exp_start});
      if (vecs[i].use_btn) begin
        goto(vecs[i].btn_at - 1);
        btn = 1'b1;
      end
      goto(vecs[i].exp_start);
      btn_sel = ~vecs[i].sel;
      auto_image = ~vecs[i].aimg;
      goto(vecs[i].exp_start + 20);
      end_checks(vecs[i].exp_img);
      btn = 1'b0;
    end

    // heartbeat with auto trigger disabled
    do_reset();
    goto(16);
    chk("hb_c16", int'(heartbeat), 0);
    goto(17);
    chk("hb_c17", int'(heartbeat), 1);
    goto(32);
    chk("hb_c32", int'(heartbeat), 1);
    goto(33);
    chk("hb_c33", int'(heartbeat), 0);
    goto(60);
    chk("hb_no_auto_busy", int'(busy), 0);

    // bounce rejection then one clean press
    do_reset();
    btn_sel = 2'b01;
    for (int p = 1; p <= 7; p += 2) begin
      btn = 1'b1;
      repeat (p) @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
    end
    goto(40);
    chk("bounce_busy", int'(busy), 0);
    q.push_back('{2'b01, 51});
    btn = 1'b1;
    goto(52);
    btn = 1'b0;
    goto(80);
    end_checks(2'b01);

    // auto_en dropped after two ticks restarts the count
    do_reset();
    auto_en = 1'b1;
    auto_image = 2'b10;
    q.push_back('{2'b10, 82});
    goto(40);
    auto_en = 1'b0;
    goto(44);
    auto_en = 1'b1;
    goto(81);
    chk("auto_drop_busy", int'(busy), 0);
    goto(100);
    end_checks(2'b10);

    // presses after the request are dropped
    do_reset();
    btn_sel = 2'b11;
    q.push_back('{2'b11, 11});
    btn = 1'b1;
    goto(12);
    btn = 1'b0;
    goto(16);
    btn_sel = 2'b00;
    btn = 1'b1;
    goto(40);
    btn = 1'b0;
    goto(70);
    btn = 1'b1;
    goto(100);
    end_checks(2'b11);
    btn = 1'b0;

    // reset in the third FIRE cycle
    do_reset();
    btn_sel = 2'b10;
    q.push_back('{2'b10, 11});
    btn = 1'b1;
    goto(17);
    chk("pre_rst_boot", int'(boot), 1);
    rst = 1'b1;
    #1;
    chk("arst_boot", int'(boot), 0);
    chk("arst_s1", int'(s1), 0);
    chk("arst_s0", int'(s0), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    btn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    btn_sel = 2'b01;
    q.push_back('{2'b01, 11});
    btn = 1'b1;
    goto(40);
    end_checks(2'b01);
    btn = 1'b0;

    chk("final_queue", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
